// File: rtl/ift_pkg.sv
// Shared taint-tracking definitions for the IFT pipeline stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ift_pkg;

    // Every taint word in the IFT pipeline is 32 bits wide.
    localparam int TAINT_W = 32;

    // Data carrying unknown bits is not trusted to carry a meaningful taint,
    // so its taint is cleared rather than propagated.
    function automatic logic [TAINT_W-1:0] taint_gate(
        input logic               data_has_x,
        input logic [TAINT_W-1:0] taint
    );
        return data_has_x ? {TAINT_W{1'b0}} : taint;
    endfunction

endpackage

// File: rtl/ift_fifo_ctrl.sv
// FIFO bookkeeping: pointers, occupancy count, registered FULL/EMPTY, sticky flag taint.
// Latency: accept strobes are combinational from pre-edge state; flags update on the edge.
// Backpressure: writes refused while full, reads refused while empty; refused requests leave all state untouched.
// Ports: i_clk/i_arst_n; i_wr_en(+_t), i_rd_en(+_t) requests; o_wr_acc/o_rd_acc accept strobes;
//        o_wp/o_rp storage addresses; o_full/o_empty flags; o_flag_t taint shared by both flags.
module ift_fifo_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TAINT_W = ift_pkg::TAINT_W,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               i_wr_en,
    input  logic [TAINT_W-1:0] i_wr_en_t,
    input  logic               i_rd_en,
    input  logic [TAINT_W-1:0] i_rd_en_t,
    output logic               o_wr_acc,
    output logic               o_rd_acc,
    output logic [AW-1:0]      o_wp,
    output logic [AW-1:0]      o_rp,
    output logic               o_full,
    output logic               o_empty,
    output logic [TAINT_W-1:0] o_flag_t
);

    localparam int          CW      = AW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [AW-1:0]      r_wp;
    logic [AW-1:0]      r_rp;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               r_full;
    logic               r_empty;
    logic [TAINT_W-1:0] r_flag_t;
    logic               w_wr_acc;
    logic               w_rd_acc;

    assign w_wr_acc = i_wr_en & ~r_full;
    assign w_rd_acc = i_rd_en & ~r_empty;

    // Simultaneous accepted push and pop leave the occupancy unchanged.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_flag_t <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (w_wr_acc) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_rd_acc) begin
                r_rp <= r_rp + AW'(1);
            end
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CNT_MAX);
            r_empty <= (w_cnt_nxt == '0);
            // Only accepted requests can influence the flags, so only they taint them.
            r_flag_t <= r_flag_t
                      | (w_wr_acc ? i_wr_en_t : {TAINT_W{1'b0}})
                      | (w_rd_acc ? i_rd_en_t : {TAINT_W{1'b0}});
        end
    end

    assign o_wr_acc = w_wr_acc;
    assign o_rd_acc = w_rd_acc;
    assign o_wp     = r_wp;
    assign o_rp     = r_rp;
    assign o_full   = r_full;
    assign o_empty  = r_empty;
    assign o_flag_t = r_flag_t;

endmodule

// File: rtl/ift_sync_fifo.sv
// Taint-tracked synchronous FIFO: stores data plus a per-entry taint word, presents registered Q/Q_t.
// Latency: Q/Q_t valid one cycle after an accepted RD_EN; Q/Q_t hold otherwise; no write-to-read bypass.
// Backpressure: WR_EN ignored while FULL, RD_EN ignored while EMPTY.
// Ports: CLK/ARST_N; WR_EN(+_t), D(+_t) push side; RD_EN(+_t) pop side;
//        Q/Q_t read data and taint; FULL/EMPTY status with shared taint FLAG_t.
module ift_sync_fifo #(
    parameter int WIDTH   = 2,
    parameter int DEPTH   = 4,
    parameter int TAINT_W = ift_pkg::TAINT_W
) (
    input  logic               CLK,
    input  logic               ARST_N,
    input  logic               WR_EN,
    input  logic [TAINT_W-1:0] WR_EN_t,
    input  logic [WIDTH-1:0]   D,
    input  logic [TAINT_W-1:0] D_t,
    input  logic               RD_EN,
    input  logic [TAINT_W-1:0] RD_EN_t,
    output logic [WIDTH-1:0]   Q,
    output logic [TAINT_W-1:0] Q_t,
    output logic               FULL,
    output logic               EMPTY,
    output logic [TAINT_W-1:0] FLAG_t
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem   [DEPTH];
    logic [TAINT_W-1:0] r_mem_t [DEPTH];
    logic [WIDTH-1:0]   r_q;
    logic [TAINT_W-1:0] r_q_t;

    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [AW-1:0]      w_wp;
    logic [AW-1:0]      w_rp;
    logic               w_d_has_x;
    logic [TAINT_W-1:0] w_wr_t;

    ift_fifo_ctrl #(
        .DEPTH   (DEPTH),
        .TAINT_W (TAINT_W),
        .AW      (AW)
    ) u_ctrl (
        .i_clk     (CLK),
        .i_arst_n  (ARST_N),
        .i_wr_en   (WR_EN),
        .i_wr_en_t (WR_EN_t),
        .i_rd_en   (RD_EN),
        .i_rd_en_t (RD_EN_t),
        .o_wr_acc  (w_wr_acc),
        .o_rd_acc  (w_rd_acc),
        .o_wp      (w_wp),
        .o_rp      (w_rp),
        .o_full    (FULL),
        .o_empty   (EMPTY),
        .o_flag_t  (FLAG_t)
    );

    // Any unknown bit in D makes the XOR reduction unknown; in 2-state flows this is constant 0.
    assign w_d_has_x = ((^D) === 1'bx);
    // Write enable taint joins the data taint because it decided whether the entry exists.
    assign w_wr_t    = ift_pkg::taint_gate(w_d_has_x, D_t | WR_EN_t);

    // Data storage needs no reset: an entry is never read before it is written.
    always_ff @(posedge CLK) begin
        if (w_wr_acc) begin
            r_mem[w_wp] <= D;
        end
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_t[i] <= '0;
            end
            r_q   <= '0;
            r_q_t <= '0;
        end else begin
            if (w_wr_acc) begin
                r_mem_t[w_wp] <= w_wr_t;
            end
            // Write and read never target the same slot in one cycle: an accepted read
            // implies non-empty, an accepted write implies non-full, so rp != wp.
            if (w_rd_acc) begin
                r_q   <= r_mem[w_rp];
                r_q_t <= r_mem_t[w_rp] | RD_EN_t;
            end
        end
    end

    assign Q   = r_q;
    assign Q_t = r_q_t;

endmodule

// File: tb/tb_ift_sync_fifo.sv
// Self-checking bench for ift_sync_fifo with a queue-based scoreboard.
// Latency: read results compared one cycle after the accepted pop.
// Backpressure: bench model tracks occupancy to predict refused pushes/pops.
module tb_ift_sync_fifo;

    localparam int W  = 2;
    localparam int DP = 4;
    localparam int TW = 32;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [TW-1:0] t;
    } ent_t;

    logic          CLK = 1'b0;
    logic          ARST_N = 1'b0;
    logic          WR_EN = 1'b0;
    logic [TW-1:0] WR_EN_t = '0;
    logic [W-1:0]  D = '0;
    logic [TW-1:0] D_t = '0;
    logic          RD_EN = 1'b0;
    logic [TW-1:0] RD_EN_t = '0;
    logic [W-1:0]  Q;
    logic [TW-1:0] Q_t;
    logic          FULL;
    logic          EMPTY;
    logic [TW-1:0] FLAG_t;

    ift_sync_fifo #(.WIDTH(W), .DEPTH(DP), .TAINT_W(TW)) dut (
        .CLK     (CLK),
        .ARST_N  (ARST_N),
        .WR_EN   (WR_EN),
        .WR_EN_t (WR_EN_t),
        .D       (D),
        .D_t     (D_t),
        .RD_EN   (RD_EN),
        .RD_EN_t (RD_EN_t),
        .Q       (Q),
        .Q_t     (Q_t),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .FLAG_t  (FLAG_t)
    );

    always #5 CLK = ~CLK;

    ent_t          sb[$];
    int            m_cnt   = 0;
    logic [TW-1:0] m_flag  = '0;
    logic [W-1:0]  exp_q   = '0;
    logic [TW-1:0] exp_qt  = '0;
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic model_reset();
        sb.delete();
        m_cnt  = 0;
        m_flag = '0;
        exp_q  = '0;
        exp_qt = '0;
    endtask

    // One clock of stimulus: drive at the falling edge, update the model from
    // pre-edge occupancy, return #1 after the rising edge with inputs idled.
    task automatic step(input logic wr, input logic [W-1:0] d, input logic [TW-1:0] dt,
                        input logic [TW-1:0] wt, input logic rd, input logic [TW-1:0] rt);
        logic wa;
        logic ra;
        ent_t e;
        @(negedge CLK);
        WR_EN = wr; D = d; D_t = dt; WR_EN_t = wt;
        RD_EN = rd; RD_EN_t = rt;
        wa = wr && (m_cnt != DP);
        ra = rd && (m_cnt != 0);
        if (ra) begin
            e = sb.pop_front();
            exp_q  = e.d;
            exp_qt = e.t | rt;
            m_flag = m_flag | rt;
        end
        if (wa) begin
            e.d = d;
            e.t = ((^d) === 1'bx) ? '0 : (dt | wt);
            sb.push_back(e);
            m_flag = m_flag | wt;
        end
        m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
        @(posedge CLK);
        #1;
        WR_EN = 1'b0; RD_EN = 1'b0;
        WR_EN_t = '0; RD_EN_t = '0; D_t = '0;
    endtask

    task automatic test_reset();
        ARST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_total++;
        if ({Q, Q_t, FULL, EMPTY, FLAG_t} !== {2'b00, 32'h0, 1'b0, 1'b1, 32'h0})
            $display("FAIL reset_state: Q=%h Q_t=%h FULL=%b EMPTY=%b FLAG_t=%h, need 0/0/0/1/0",
                     Q, Q_t, FULL, EMPTY, FLAG_t);
        else n_pass++;
        @(negedge CLK);
        ARST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        logic [W-1:0]  q_tab [3];
        logic [TW-1:0] t_tab [3];
        q_tab = '{2'd1, 2'd2, 2'd3};
        t_tab = '{32'h111, 32'h112, 32'h110};
        step(1'b1, 2'd1, 32'h1, 32'h10, 1'b0, '0);
        step(1'b1, 2'd2, 32'h2, 32'h10, 1'b0, '0);
        step(1'b1, 2'd3, 32'h0, 32'h10, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 32'h100);
            n_total++;
            if (Q !== q_tab[i] || Q_t !== t_tab[i])
                $display("FAIL basic_pop%0d: Q=%h Q_t=%h, need %h/%h", i, Q, Q_t, q_tab[i], t_tab[i]);
            else n_pass++;
        end
        n_total++;
        if (FLAG_t !== 32'h110 || EMPTY !== 1'b1)
            $display("FAIL basic_flags: FLAG_t=%h EMPTY=%b, need 110/1", FLAG_t, EMPTY);
        else n_pass++;
    endtask

    task automatic test_full_and_simul();
        for (int i = 0; i < DP; i++) begin
            step(1'b1, W'(i), 32'h1000 << i, 32'h20, 1'b0, '0);
        end
        n_total++;
        if (FULL !== 1'b1 || EMPTY !== 1'b0)
            $display("FAIL fill_flags: FULL=%b EMPTY=%b, need 1/0", FULL, EMPTY);
        else n_pass++;
        // Rejected push: its enable taint must not reach FLAG_t.
        step(1'b1, 2'd0, 32'hDEAD, 32'h4000_0000, 1'b0, '0);
        n_total++;
        if (FULL !== 1'b1 || FLAG_t !== m_flag)
            $display("FAIL overflow_reject: FULL=%b FLAG_t=%h, need 1/%h", FULL, FLAG_t, m_flag);
        else n_pass++;
        // Full with both requests: only the pop is taken.
        step(1'b1, 2'd3, 32'h7, 32'h8, 1'b1, 32'h200);
        n_total++;
        if (FULL !== 1'b0 || Q !== 2'd0 || Q_t !== 32'h1220)
            $display("FAIL full_both: FULL=%b Q=%h Q_t=%h, need 0/0/1220", FULL, Q, Q_t);
        else n_pass++;
        for (int i = 1; i < DP; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 32'h0);
            n_total++;
            if (Q !== exp_q || Q_t !== exp_qt || Q !== W'(i))
                $display("FAIL drain%0d: Q=%h Q_t=%h, need %h/%h", i, Q, Q_t, exp_q, exp_qt);
            else n_pass++;
        end
        n_total++;
        if (EMPTY !== 1'b1 || m_cnt != 0)
            $display("FAIL drain_empty: EMPTY=%b, need 1", EMPTY);
        else n_pass++;
        // Empty pop is refused: Q/Q_t hold.
        step(1'b0, '0, '0, '0, 1'b1, 32'h8000);
        n_total++;
        if (Q !== 2'd3 || Q_t !== exp_qt || FLAG_t !== m_flag)
            $display("FAIL underflow_hold: Q=%h Q_t=%h FLAG_t=%h, need 3/%h/%h", Q, Q_t, FLAG_t, exp_qt, m_flag);
        else n_pass++;
        // Empty with both requests: only the push is taken.
        step(1'b1, 2'd2, 32'h40, 32'h0, 1'b1, 32'h1_0000);
        n_total++;
        if (EMPTY !== 1'b0 || Q !== 2'd3 || FLAG_t !== m_flag)
            $display("FAIL empty_both: EMPTY=%b Q=%h FLAG_t=%h, need 0/3/%h", EMPTY, Q, FLAG_t, m_flag);
        else n_pass++;
        step(1'b0, '0, '0, '0, 1'b1, 32'h0);
        n_total++;
        if (Q !== 2'd2 || Q_t !== 32'h40 || EMPTY !== 1'b1)
            $display("FAIL empty_both_pop: Q=%h Q_t=%h EMPTY=%b, need 2/40/1", Q, Q_t, EMPTY);
        else n_pass++;
    endtask

    task automatic test_x_data();
        logic [W-1:0] dx;
        dx = 2'bx1;
        step(1'b1, dx, 32'hFF, 32'h1, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 32'h0);
        // Expectation follows whether the unknown actually reached the port in this simulator.
        n_total++;
        if (Q_t !== exp_qt)
            $display("FAIL x_taint: Q_t=%h, need %h", Q_t, exp_qt);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [TW-1:0] rt;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, W'(i + 1), TW'($urandom), TW'(1) << (i % 8), 1'b0, '0);
            if (i % 2 == 1) step(1'b1, W'(i), TW'($urandom), '0, 1'b0, '0);
            rt = TW'($urandom);
            step(1'b0, '0, '0, '0, 1'b1, rt);
            n_total++;
            if (Q !== exp_q || Q_t !== exp_qt)
                $display("FAIL wrap%0d: Q=%h Q_t=%h, need %h/%h", i, Q, Q_t, exp_q, exp_qt);
            else n_pass++;
        end
        while (m_cnt > 0) begin
            step(1'b0, '0, '0, '0, 1'b1, 32'h0);
            n_total++;
            if (Q !== exp_q || Q_t !== exp_qt)
                $display("FAIL wrap_drain: Q=%h Q_t=%h, need %h/%h", Q, Q_t, exp_q, exp_qt);
            else n_pass++;
        end
        n_total++;
        if (FLAG_t !== m_flag || EMPTY !== 1'b1)
            $display("FAIL wrap_flags: FLAG_t=%h EMPTY=%b, need %h/1", FLAG_t, EMPTY, m_flag);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(1'b1, 2'd1, 32'h3, 32'h0, 1'b0, '0);
        step(1'b1, 2'd2, 32'h4, 32'h0, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 32'h9);
        // Mid-cycle asynchronous reset must clear outputs before the next edge.
        #2;
        ARST_N = 1'b0;
        #1;
        n_total++;
        if ({Q, Q_t, FULL, EMPTY, FLAG_t} !== {2'b00, 32'h0, 1'b0, 1'b1, 32'h0})
            $display("FAIL async_reset: Q=%h Q_t=%h FULL=%b EMPTY=%b FLAG_t=%h, need 0/0/0/1/0",
                     Q, Q_t, FULL, EMPTY, FLAG_t);
        else n_pass++;
        model_reset();
        @(negedge CLK);
        ARST_N = 1'b1;
        step(1'b1, 2'd3, 32'h5, 32'h0, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 32'h0);
        n_total++;
        if (Q !== 2'd3 || Q_t !== 32'h5 || EMPTY !== 1'b1)
            $display("FAIL reset_restart: Q=%h Q_t=%h EMPTY=%b, need 3/5/1", Q, Q_t, EMPTY);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_and_simul();
        test_x_data();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ift_sync_fifo.md
Name: ift_sync_fifo

Overview:
- Clocked FIFO stage with information-flow tracking (IFT), placed downstream of the taint-tracked enable latch.
- Buffers the latch's data output Q together with its 32-bit taint word Q_t, then presents them to the next stage.
- Each data entry carries its own taint word.
- Control taint (from the write/read enables) propagates into the read data and the status flags.

Parameters:
- WIDTH, 2, data width in bits.
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- TAINT_W, 32, taint word width; matches the codebase-wide 32-bit taint convention.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ARST_N  input  1  asynchronous active-low reset.
- WR_EN  input  1  push request.
- WR_EN_t  input  TAINT_W  taint of WR_EN.
- D  input  WIDTH  write data.
- D_t  input  TAINT_W  taint of D.
- RD_EN  input  1  pop request.
- RD_EN_t  input  TAINT_W  taint of RD_EN.
- Q  output  WIDTH  registered read data.
- Q_t  output  TAINT_W  taint of Q.
- FULL  output  1  all DEPTH entries occupied.
- EMPTY  output  1  no entries occupied.
- FLAG_t  output  TAINT_W  taint shared by FULL and EMPTY.

Behaviour:
- Reset (ARST_N=0, asynchronous, takes effect immediately):
  - Q=0, Q_t=0, FULL=0, EMPTY=1, FLAG_t=0.
  - Write pointer, read pointer and count = 0.
  - All stored taint words = 0; stored data is don't-care.
- Reset deasserted mid-operation: the FIFO restarts empty. Data pushed before reset is never returned.
- Accept conditions:
  - wr_acc = WR_EN & ~FULL.
  - rd_acc = RD_EN & ~EMPTY.
  - Both are evaluated on pre-edge state.
- Write (wr_acc):
  - mem[wp] <= D.
  - mem_t[wp] <= 0 if D contains any X/Z bit (reduction-XOR === X); otherwise D_t | WR_EN_t.
  - wp advances by 1, modulo DEPTH.
- Read (rd_acc):
  - Q <= mem[rp].
  - Q_t <= mem_t[rp] | RD_EN_t.
  - rp advances by 1, modulo DEPTH.
- Read latency: data appears on Q one cycle after the accepted RD_EN edge.
- Q and Q_t hold their value when there is no accepted read.
- Count:
  - +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
  - Count width is log2(DEPTH)+1.
- Flags:
  - EMPTY = (count==0), FULL = (count==DEPTH).
  - Registered: they reflect post-edge state.
- Boundary cases:
  - Full with WR_EN=1 and RD_EN=1: read accepted, write rejected; FIFO ends with DEPTH-1 entries.
  - Empty with WR_EN=1 and RD_EN=1: write accepted, read rejected; Q and Q_t hold.
  - Neither flag case, both requests: both accepted; count unchanged; pointers each advance.
  - Rejected operations change no state, including taint.
  - Pointer wrap-around from DEPTH-1 to 0 is seamless; there is no bypass path.
- Flag taint (FLAG_t):
  - FLAG_t <= FLAG_t | (wr_acc ? WR_EN_t : 0) | (rd_acc ? RD_EN_t : 0).
  - Sticky until reset.
  - Rejected requests do not contribute.

Decomposition:
- Shared package ift_pkg:
  - localparam TAINT_W=32.
  - Function taint_gate(data_has_x, taint), which returns 0 when data_has_x is set. The latch stages reuse this function.
- One sub-module, ift_fifo_ctrl: pointers, count, FULL/EMPTY and FLAG_t.
- The top level holds the data and taint storage arrays and the Q/Q_t registers.

Test Plan:
- Reset → Q=0, Q_t=0, EMPTY=1, FULL=0, FLAG_t=0; assert ARST_N low mid-cycle and check outputs clear before the next edge.
- Push D=1/D_t=0x1, D=2/D_t=0x2, D=3/D_t=0x0 with WR_EN_t=0x10, then pop 3× with RD_EN_t=0x100 → Q=1,2,3 with Q_t=0x111, 0x112, 0x110; FLAG_t=0x110; EMPTY=1 after the 3rd pop.
- Fill 4 entries, then a 5th push D=0 → FULL=1; the 5th push is rejected; later pops return only the first 4 values.
- When full, push and pop in the same cycle → FULL=0, count=3, Q=oldest entry. When empty, push and pop in the same cycle → EMPTY=0, Q unchanged.
- Push D=2'bx1 with D_t=0xFF and WR_EN_t=0x1, then pop with RD_EN_t=0 → Q_t=0.
- Perform 10 push/pop pairs to cross the pointer wrap → strict FIFO order holds; each Q_t equals its stored taint OR RD_EN_t.
- Push 2 entries, pulse ARST_N low, then push D=3 and pop → Q=3; the old entries are never returned.
